store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of store entries; SHALL be a power of two, 2..16.
REQ-002 Parameter MEM_TIMEOUT_W, default 8, width of the per-request wait counter.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 Ports, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_addr  in  32  CPU data address.
- cpu_wdata  in  32  CPU store data.
- cpu_read  in  1  CPU load request.
- cpu_write  in  1  CPU store request.
- cpu_rdata  out  32  load data returned to the CPU.
- stall  out  1  CPU must hold its current instruction.
- mem_req  out  1  memory bus request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data.
- mem_ack  in  1  memory completion, one-cycle pulse.
- buf_count  out  5  number of occupied entries.
- timeout  out  1  sticky flag; set when a request waits 2^MEM_TIMEOUT_W-1 cycles.

Function
REQ-005 Buffer: circular FIFO of DEPTH {addr, data} entries with head/tail pointers that wrap modulo DEPTH; buf_count is registered.
REQ-006 Store, buffer not full: entry enqueued at the clock edge; stall=0 in that cycle.
REQ-007 Store, buffer full (registered count = DEPTH): stall=1 combinationally and no enqueue, even if a pop occurs in the same cycle; the store is retried next cycle.
REQ-008 Both cpu_read and cpu_write asserted: treated as a store; the read is ignored.
REQ-009 Drain FSM has states IDLE, WR, RD.
- IDLE to RD: a load miss is pending.
- IDLE to WR: otherwise, if the buffer is non-empty.
REQ-010 WR state: mem_req=1, mem_we=1, mem_addr/mem_wdata = head entry.
- On mem_ack: pop head and return to IDLE.
REQ-011 RD state: mem_req=1, mem_we=0, mem_addr=cpu_addr.
- On mem_ack: cpu_rdata=mem_rdata combinationally, stall=0, return to IDLE.
REQ-012 Load miss: stall=1 from the first cycle of the load until the cycle of its mem_ack.
- An in-flight WR completes first.
- The read is then issued before the remaining stores, since no buffered entry matches the address.
REQ-013 mem_addr, mem_wdata and mem_we SHALL stay stable while mem_req=1 until mem_ack; mem_req=0 in IDLE.
REQ-014 At most one memory transaction is outstanding; mem_ack received in IDLE is ignored.
REQ-015 Timeout counter:
- Clears on entering WR or RD; increments each cycle without mem_ack; saturates.
- At 2^MEM_TIMEOUT_W-1 it sets timeout, which stays set until reset.
- The request remains asserted.
REQ-016 Address compare uses all 32 bits; no byte enables; every store is a full word.
REQ-017 When no load is active, cpu_rdata SHALL be 0.

Reset
REQ-018 While rst=0:
- FSM=IDLE, head=tail=0, buf_count=0.
- mem_req=0, mem_we=0, stall=0, timeout=0, counter=0.
- mem_addr, mem_wdata and cpu_rdata = 0.
REQ-019 Entry valid state clears on reset; entry contents need not.
REQ-020 Reset mid-transaction drops mem_req asynchronously; buffered stores are discarded.

Configuration
REQ-021 Macro STORE_FWD_EN.
- Defined: a load whose address matches any buffered entry (including the head in WR) returns the youngest match on cpu_rdata combinationally, with stall=0 and no memory access.
- Undefined: any load stalls until the buffer is empty and no WR is in flight, then proceeds as a load miss.

Verification
REQ-022 Scenarios:
- Empty buffer, store 0x100<-0xDEADBEEF, mem_ack 3 cycles after mem_req -> no stall; WR shows addr 0x100, data 0xDEADBEEF; buf_count 1->0.
- DEPTH=4, five back-to-back stores with mem_ack held low -> stall=1 on the 5th; buf_count=4; first mem_ack pops, and the 5th enqueues on the following cycle.
- Stores 0x200<-1, then 0x200<-2, load 0x200 -> STORE_FWD_EN: cpu_rdata=2 with stall=0 and no RD; undefined: RD issues after two WRs, cpu_rdata=mem_rdata.
- Load 0x300 while WR in flight, mem_rdata=0x55 -> RD only after the WR ack; stall held; cpu_rdata=0x55 in the ack cycle.
- mem_ack withheld 255 cycles in WR (MEM_TIMEOUT_W=8) -> timeout=1, mem_req still 1, addr/data stable.
- rst=0 during WR with 3 entries -> mem_req=0 immediately, buf_count=0, stall=0.

Source files
------------

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//
// Write-back store buffer between a CPU data port and a single-outstanding
// memory bus. Stores are queued in a circular FIFO and drained to memory
// one at a time by a small IDLE/WR/RD state machine. Loads go to memory
// as reads, so the CPU is stalled until the read returns.
//
// Build option:
//   STORE_FWD_EN  defined   : loads that hit a buffered store return the
//                             youngest matching data at once, with no stall.
//                             A load miss is issued ahead of the remaining
//                             buffered stores once any in-flight WR completes.
//                 undefined : every load waits until the buffer is empty and
//                             no WR is in flight, then reads memory.
//
// Parameters:
//   DEPTH          number of store entries (power of two, 2..16)
//   MEM_TIMEOUT_W  width of the per-request wait counter
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous, active-low reset
//   cpu_addr   CPU data address
//   cpu_wdata  CPU store data
//   cpu_read   CPU load request
//   cpu_write  CPU store request (wins over cpu_read if both are high)
//   cpu_rdata  load data returned to the CPU, 0 when no load completes
//   stall      CPU must hold its current instruction
//   mem_req    memory bus request
//   mem_we     1 = write, 0 = read
//   mem_addr   memory address
//   mem_wdata  memory write data
//   mem_rdata  memory read data
//   mem_ack    memory completion, one-cycle pulse
//   buf_count  number of occupied entries
//   timeout    sticky flag, set when a request waits 2^MEM_TIMEOUT_W-1 cycles
// ---------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH         = 4,
  parameter int MEM_TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [4:0]  buf_count,
  output logic        timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;

  localparam int                       PW       = $clog2(DEPTH);
  localparam logic [4:0]               FULL_CNT = 5'(DEPTH);
  localparam logic [MEM_TIMEOUT_W-1:0] WAIT_MAX = '1;

  // Entry storage and FIFO bookkeeping. The occupancy count is the only
  // validity state: entries outside [head, head+count) are dead.
  logic [31:0]              r_addr [DEPTH];
  logic [31:0]              r_data [DEPTH];
  logic [PW-1:0]            r_head;
  logic [PW-1:0]            r_tail;
  logic [4:0]               r_count;

  logic [1:0]               r_state;
  logic [1:0]               w_state_nxt;
  logic [MEM_TIMEOUT_W-1:0] r_wait;
  logic                     r_timeout;

  logic                     w_load;
  logic                     w_full;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_rd_done;
  logic                     w_rd_go;
  logic                     w_hit;
  logic [31:0]              w_fwd_data;
  logic [PW-1:0]            w_fwd_idx;
  logic                     w_stall_raw;

  // A simultaneous read+write is a store; the read half is dropped.
  assign w_load    = cpu_read & ~cpu_write;
  // Fullness uses the registered count only, so a pop in the same cycle
  // cannot make room for the incoming store.
  assign w_full    = (r_count == FULL_CNT);
  assign w_push    = cpu_write & ~w_full;
  assign w_pop     = (r_state == S_WR) & mem_ack;
  assign w_rd_done = (r_state == S_RD) & mem_ack;

`ifdef STORE_FWD_EN
  // Scan oldest to youngest so the last match (youngest store) wins. The
  // head is still live while its WR is in flight, so it takes part too.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before
    // any conditional assignment, otherwise synthesis infers a latch.
    w_hit      = 1'b0;
    w_fwd_data = '0;
    w_fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_fwd_idx = r_head + PW'(i);
      if ((5'(i) < r_count) && (r_addr[w_fwd_idx] == cpu_addr)) begin
        w_hit      = 1'b1;
        w_fwd_data = r_data[w_fwd_idx];
      end
    end
  end

  assign w_rd_go = w_load & ~w_hit;
`else
  assign w_hit      = 1'b0;
  assign w_fwd_data = '0;
  assign w_fwd_idx  = '0;
  // Without forwarding a load may only read memory once every older
  // store has been written back.
  assign w_rd_go    = w_load & (r_count == 5'd0);
`endif

  // Drain FSM. A pending load miss takes priority over draining stores;
  // an in-flight WR is never abandoned.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rd_go)                w_state_nxt = S_RD;
        else if (r_count != 5'd0)   w_state_nxt = S_WR;
      end
      S_WR:    if (mem_ack) w_state_nxt = S_IDLE;
      S_RD:    if (mem_ack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      r_state <= S_IDLE;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      r_count <= r_count + {4'b0, w_push} - {4'b0, w_pop};
    end
  end

  // NOTE: the entry array has no reset; r_count alone says which entries
  // are valid, and leaving the RAM unreset lets it map onto plain storage.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= cpu_addr;
      r_data[r_tail] <= cpu_wdata;
    end
  end

  // Wait counter: cleared on the way into WR/RD, counts cycles without an
  // ack and sticks at its maximum. The flag rises on the edge where the
  // counter reaches the maximum and stays up until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_state_nxt != S_IDLE) r_wait <= '0;
    end else if (!mem_ack && (r_wait != WAIT_MAX)) begin
      r_wait <= r_wait + 1'b1;
      if (r_wait == WAIT_MAX - 1'b1) r_timeout <= 1'b1;
    end
  end

  // CPU side. A store stalls only when the buffer is full; a load stalls
  // until it is forwarded or its read ack arrives. Reset forces stall low.
  always_comb begin
    w_stall_raw = 1'b0;
    if (cpu_write)     w_stall_raw = w_full;
    else if (cpu_read) w_stall_raw = ~(w_hit | w_rd_done);
  end

  assign stall = rst & w_stall_raw;

  always_comb begin
    cpu_rdata = '0;
    if (w_load && w_rd_done)  cpu_rdata = mem_rdata;
    else if (w_load && w_hit) cpu_rdata = w_fwd_data;
  end

  // Memory side is decoded straight from the state register, so it drops
  // with the asynchronous reset and holds steady for a whole transaction
  // (the head only moves on the ack, the CPU holds cpu_addr while stalled).
  assign mem_req   = (r_state == S_WR) | (r_state == S_RD);
  assign mem_we    = (r_state == S_WR);
  assign mem_addr  = (r_state == S_WR) ? r_addr[r_head] :
                     (r_state == S_RD) ? cpu_addr       : 32'd0;
  assign mem_wdata = (r_state == S_WR) ? r_data[r_head] : 32'd0;

  assign buf_count = r_count;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_buffer
//
// Directed bench for store_buffer (DEPTH=4, MEM_TIMEOUT_W=8). Inputs change
// one time unit after the falling edge and outputs are sampled one unit
// later, well away from the rising edge. The memory side is played by hand:
// the bench raises mem_ack when each step calls for it. Expected values are
// written out by hand for each step; the load-ordering steps follow the
// STORE_FWD_EN build option.
// ---------------------------------------------------------------------------
module tb_store_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [4:0]  buf_count;
  logic        timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  store_buffer #(
    .DEPTH         (4),
    .MEM_TIMEOUT_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .buf_count (buf_count),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; land just after the following falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_write = 1'b1;
    #1;
  endtask

  // Wait (bounded) for a WR of the expected entry, check it, then ack it.
  task automatic drain_one(input string tag, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    while (!(mem_req && mem_we) && n < 32) begin
      tick();
      n++;
    end
    check({tag, "_wr_req"}, {30'd0, mem_req, mem_we}, 32'd3);
    check({tag, "_wr_addr"}, mem_addr, a);
    check({tag, "_wr_data"}, mem_wdata, d);
    mem_ack = 1'b1;
    #1;
    tick();
    mem_ack = 1'b0;
    #1;
  endtask

  // Wait (bounded) for a read request to appear on the bus.
  task automatic wait_rd(input string tag);
    int n;
    n = 0;
    while (!(mem_req && !mem_we) && n < 32) begin
      tick();
      n++;
    end
    check({tag, "_rd_req"}, {30'd0, mem_req, mem_we}, 32'd2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    mem_rdata = '0;
    mem_ack   = 1'b0;

    // ---------------- reset state ----------------
    #3;
    check("rst_mem_req",   mem_req,   0);
    check("rst_mem_we",    mem_we,    0);
    check("rst_stall",     stall,     0);
    check("rst_timeout",   timeout,   0);
    check("rst_buf_count", buf_count, 0);
    check("rst_mem_addr",  mem_addr,  0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    tick();
    check("rst_hold_req",  mem_req,   0);
    rst = 1'b1;

    // ---------------- single store, ack 3 cycles after request ----------------
    store(32'h100, 32'hDEADBEEF);
    check("s1_stall", stall, 0);
    tick();
    cpu_write = 1'b0;
    #1;
    check("s1_count1",  buf_count, 1);
    check("s1_idle_req", mem_req, 0);
    tick();
    check("s1_req",   mem_req,   1);
    check("s1_we",    mem_we,    1);
    check("s1_addr",  mem_addr,  32'h100);
    check("s1_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    tick();
    check("s1_addr_stable",  mem_addr,  32'h100);
    check("s1_wdata_stable", mem_wdata, 32'hDEADBEEF);
    tick();
    mem_ack = 1'b1;
    #1;
    check("s1_count_before_pop", buf_count, 1);
    tick();
    mem_ack = 1'b0;
    #1;
    check("s1_count0",  buf_count, 0);
    check("s1_req_off", mem_req,   0);

    // ---------------- fill to full, fifth store stalls ----------------
    for (int i = 0; i < 4; i++) begin
      store(32'h1000 + 32'(i * 4), 32'hA0 + 32'(i));
      check("s2_fill_stall", stall, 0);
      tick();
    end
    store(32'h1010, 32'hA4);
    check("s2_full_stall", stall,     1);
    check("s2_full_count", buf_count, 4);
    check("s2_req",        mem_req,   1);
    check("s2_head_addr",  mem_addr,  32'h1000);
    tick();
    mem_ack = 1'b1;
    #1;
    check("s2_stall_with_pop", stall,     1);
    check("s2_count_hold",     buf_count, 4);
    tick();
    mem_ack = 1'b0;
    #1;
    check("s2_count_after_pop", buf_count, 3);
    check("s2_retry_no_stall",  stall,     0);
    tick();
    cpu_write = 1'b0;
    #1;
    check("s2_count_refill", buf_count, 4);
    drain_one("s2_e1", 32'h1004, 32'hA1);
    drain_one("s2_e2", 32'h1008, 32'hA2);
    drain_one("s2_e3", 32'h100C, 32'hA3);
    drain_one("s2_e4", 32'h1010, 32'hA4);
    check("s2_empty", buf_count, 0);

    // ---------------- two stores to one address, then load it ----------------
    store(32'h200, 32'd1);
    tick();
    store(32'h200, 32'd2);
    check("s3_store2_stall", stall, 0);
    tick();
    cpu_write = 1'b0;
    cpu_read  = 1'b1;
    cpu_addr  = 32'h200;
    #1;
`ifdef STORE_FWD_EN
    check("s3_fwd_rdata", cpu_rdata, 32'd2);
    check("s3_fwd_stall", stall,     0);
    check("s3_fwd_no_rd", mem_we,    1);
    cpu_read = 1'b0;
    #1;
    drain_one("s3_e1", 32'h200, 32'd1);
    drain_one("s3_e2", 32'h200, 32'd2);
    check("s3_fwd_empty", buf_count, 0);
`else
    check("s3_stall",       stall,     1);
    check("s3_rdata_quiet", cpu_rdata, 0);
    drain_one("s3_e1", 32'h200, 32'd1);
    check("s3_stall_mid", stall, 1);
    drain_one("s3_e2", 32'h200, 32'd2);
    wait_rd("s3");
    check("s3_rd_addr",  mem_addr, 32'h200);
    check("s3_rd_stall", stall,    1);
    mem_rdata = 32'h77;
    mem_ack   = 1'b1;
    #1;
    check("s3_rd_rdata",    cpu_rdata, 32'h77);
    check("s3_rd_unstall",  stall,     0);
    tick();
    mem_ack  = 1'b0;
    cpu_read = 1'b0;
    #1;
    check("s3_rdata_idle", cpu_rdata, 0);
    check("s3_req_idle",   mem_req,   0);
`endif

    // ---------------- load miss while a WR is in flight ----------------
    store(32'h400, 32'hA);
    tick();
    store(32'h404, 32'hB);
    tick();
    cpu_write = 1'b0;
    cpu_read  = 1'b1;
    cpu_addr  = 32'h300;
    mem_rdata = 32'h0;
    #1;
    check("s4_stall",      stall,     1);
    check("s4_wr_first",   mem_we,    1);
    check("s4_wr_addr",    mem_addr,  32'h400);
    check("s4_rdata_zero", cpu_rdata, 0);
    tick();
    check("s4_wr_addr_hold", mem_addr, 32'h400);
    mem_ack = 1'b1;
    #1;
    check("s4_stall_wr_ack", stall,     1);
    check("s4_rdata_wr_ack", cpu_rdata, 0);
    tick();
    mem_ack = 1'b0;
    #1;
    check("s4_idle_gap",  mem_req, 0);
    check("s4_stall_gap", stall,   1);
`ifndef STORE_FWD_EN
    drain_one("s4_e2", 32'h404, 32'hB);
`endif
    wait_rd("s4");
    check("s4_rd_addr",  mem_addr, 32'h300);
    check("s4_rd_stall", stall,    1);
    mem_rdata = 32'h55;
    mem_ack   = 1'b1;
    #1;
    check("s4_rd_rdata",   cpu_rdata, 32'h55);
    check("s4_rd_unstall", stall,     0);
    tick();
    mem_ack  = 1'b0;
    cpu_read = 1'b0;
    #1;
    check("s4_rdata_idle", cpu_rdata, 0);
`ifdef STORE_FWD_EN
    drain_one("s4_e2", 32'h404, 32'hB);
`endif
    check("s4_empty", buf_count, 0);

    // ---------------- ack withheld: timeout ----------------
    store(32'h500, 32'h1234);
    tick();
    cpu_write = 1'b0;
    #1;
    tick();
    check("s5_req",        mem_req, 1);
    check("s5_timeout_lo", timeout, 0);
    repeat (254) tick();
    check("s5_timeout_254", timeout, 0);
    tick();
    check("s5_timeout_255", timeout,   1);
    check("s5_req_held",    mem_req,   1);
    check("s5_addr_stable", mem_addr,  32'h500);
    check("s5_data_stable", mem_wdata, 32'h1234);
    drain_one("s5_e1", 32'h500, 32'h1234);
    check("s5_timeout_sticky", timeout, 1);

    // ---------------- reset during WR with three entries ----------------
    store(32'h600, 32'h6);
    tick();
    store(32'h604, 32'h7);
    tick();
    store(32'h608, 32'h8);
    tick();
    cpu_write = 1'b0;
    #1;
    check("s6_count3", buf_count, 3);
    check("s6_req",    mem_req,   1);
    check("s6_addr",   mem_addr,  32'h600);
    rst = 1'b0;
    #1;
    check("s6_rst_req",     mem_req,   0);
    check("s6_rst_count",   buf_count, 0);
    check("s6_rst_stall",   stall,     0);
    check("s6_rst_timeout", timeout,   0);
    check("s6_rst_addr",    mem_addr,  0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("s6_post_count", buf_count, 0);
    check("s6_post_req",   mem_req,   0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
